// File: rtl/fb_frame_ctrl.sv
// Double-buffered framebuffer frame scheduler: clear back buffer, start render,
// wait for done, swap at a frame boundary. Define FB_FRAME_CTRL_CLEAR_EN to enable the clear pass.
module fb_frame_ctrl #(
    parameter int FB_PIXELS  = 57600,
    parameter int FB_ADDRW   = $clog2(FB_PIXELS),
    parameter int FB_DATAW   = 4,
    parameter int BG_CIDX    = 0,
    parameter int FRAME_WAIT = 1
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                frame_sys,
    input  logic                render_done,
    output logic                render_start,
    output logic                buf_draw,
    output logic                buf_disp,
    output logic                clr_we,
    output logic [FB_ADDRW-1:0] clr_addr,
    output logic [FB_DATAW-1:0] clr_colr,
    output logic                busy,
    output logic                overrun
);

    localparam int CNT_W = (FRAME_WAIT > 1) ? $clog2(FRAME_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, START, DRAW, WAIT} state_t;

`ifdef FB_FRAME_CTRL_CLEAR_EN
    localparam state_t FILL = CLEAR;
`else
    localparam state_t FILL = START;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             disp_q, disp_d;
    logic             rstart_q, rstart_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             swap, frame_in, clr_last;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            disp_q   <= 1'b0;
            rstart_q <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            rstart_q <= rstart_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    // A frame arriving together with render_done in DRAW is handled as if WAIT saw it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        swap     = 1'b0;
        frame_in = 1'b0;
        case (state_q)
            IDLE:    if (frame_sys) state_d = FILL;
            CLEAR:   if (clr_last) state_d = START;
            START:   state_d = DRAW;
            DRAW:    if (render_done) begin
                         state_d  = WAIT;
                         frame_in = frame_sys;
                     end
            WAIT:    frame_in = frame_sys;
            default: state_d = IDLE;
        endcase
        if (frame_in) begin
            if (cnt_q == CNT_W'(FRAME_WAIT - 1)) begin
                cnt_d   = '0;
                swap    = 1'b1;
                state_d = FILL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        disp_d   = disp_q ^ swap;
        rstart_d = (state_d == START);
        busy_d   = (state_d == CLEAR) || (state_d == START) || (state_d == DRAW);
        ovr_d    = frame_sys && ((state_q == CLEAR) || (state_q == START) ||
                                 ((state_q == DRAW) && !render_done));
    end

`ifdef FB_FRAME_CTRL_CLEAR_EN
    logic                we_q, we_d;
    logic [FB_ADDRW-1:0] addr_q, addr_d;

    assign clr_last = (addr_q == FB_ADDRW'(FB_PIXELS - 1));

    // Address restarts at 0 whenever CLEAR is entered and parks at 0 outside it.
    always_comb begin
        we_d   = (state_d == CLEAR);
        addr_d = ((state_q == CLEAR) && (state_d == CLEAR)) ? addr_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    assign clr_we   = we_q;
    assign clr_addr = addr_q;
`else
    assign clr_last = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign render_start = rstart_q;
    assign buf_disp     = disp_q;
    assign buf_draw     = ~disp_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;
    assign clr_colr     = FB_DATAW'(BG_CIDX);

endmodule

// File: tb/tb_fb_frame_ctrl.sv
// Bench for fb_frame_ctrl: FRAME_WAIT=1 and FRAME_WAIT=3 instances share stimulus and
// are compared each cycle against a phase-level reference model.
module tb_fb_frame_ctrl;
    localparam int N  = 16;
    localparam int AW = 4;
`ifdef FB_FRAME_CTRL_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_CLR = 1, P_START = 2, P_DRAW = 3, P_WAIT = 4;

    logic clk = 1'b0, rst_n = 1'b0, fs = 1'b0, rd = 1'b0;
    logic          rs [2], bdr [2], bdp [2], we [2], bsy [2], ov [2];
    logic [AW-1:0] ad [2];
    logic [3:0]    col [2];

    always #5 clk = ~clk;

    fb_frame_ctrl #(.FB_PIXELS(N), .FB_DATAW(4), .BG_CIDX(5), .FRAME_WAIT(1)) dut1 (
        .clk_sys(clk), .rst_sys_n(rst_n), .frame_sys(fs), .render_done(rd),
        .render_start(rs[0]), .buf_draw(bdr[0]), .buf_disp(bdp[0]), .clr_we(we[0]),
        .clr_addr(ad[0]), .clr_colr(col[0]), .busy(bsy[0]), .overrun(ov[0]));

    fb_frame_ctrl #(.FB_PIXELS(N), .FB_DATAW(4), .BG_CIDX(5), .FRAME_WAIT(3)) dut3 (
        .clk_sys(clk), .rst_sys_n(rst_n), .frame_sys(fs), .render_done(rd),
        .render_start(rs[1]), .buf_draw(bdr[1]), .buf_disp(bdp[1]), .clr_we(we[1]),
        .clr_addr(ad[1]), .clr_colr(col[1]), .busy(bsy[1]), .overrun(ov[1]));

    int errors = 0, checks = 0;
    int ph [2], addr [2], frames [2], edisp [2], eov [2];
    int fw [2] = '{1, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = P_IDLE; addr[i] = 0; frames[i] = 0; edisp[i] = 0; eov[i] = 0;
        end
    endtask

    task automatic begin_frame(input int i);
        if (CLR_EN) begin ph[i] = P_CLR; addr[i] = 0; end
        else ph[i] = P_START;
    endtask

    // Displayed frames seen since the last swap; swap once FRAME_WAIT have been seen.
    task automatic see_frame(input int i);
        frames[i]++;
        if (frames[i] == fw[i]) begin
            frames[i] = 0;
            edisp[i]  = 1 - edisp[i];
            begin_frame(i);
        end
    endtask

    task automatic model_step(input int i, input bit f, input bit r);
        eov[i] = 0;
        case (ph[i])
            P_IDLE:  if (f) begin_frame(i);
            P_CLR:   begin
                         eov[i] = f;
                         if (addr[i] == N - 1) begin ph[i] = P_START; addr[i] = 0; end
                         else addr[i]++;
                     end
            P_START: begin eov[i] = f; ph[i] = P_DRAW; end
            P_DRAW:  if (r) begin ph[i] = P_WAIT; if (f) see_frame(i); end
                     else eov[i] = f;
            default: if (f) see_frame(i);
        endcase
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("render_start%0d", i), 32'(rs[i]), 32'(ph[i] == P_START));
            check($sformatf("clr_we%0d", i), 32'(we[i]), 32'(ph[i] == P_CLR));
            check($sformatf("clr_addr%0d", i), 32'(ad[i]), (ph[i] == P_CLR) ? addr[i] : 0);
            check($sformatf("buf_disp%0d", i), 32'(bdp[i]), edisp[i]);
            check($sformatf("buf_draw%0d", i), 32'(bdr[i]), 1 - edisp[i]);
            check($sformatf("busy%0d", i), 32'(bsy[i]),
                  32'(ph[i] == P_CLR || ph[i] == P_START || ph[i] == P_DRAW));
            check($sformatf("overrun%0d", i), 32'(ov[i]), eov[i]);
            check($sformatf("clr_colr%0d", i), 32'(col[i]), 5);
        end
    endtask

    task automatic step(input bit f, input bit r);
        fs = f; rd = r;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, f, r);
        #1;
        fs = 1'b0; rd = 1'b0;
        check_all();
    endtask

    // Reset lands mid-cycle; outputs must return to reset values without a clock edge.
    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_draw(input int i);
        int n = 0;
        while (ph[i] != P_DRAW && n < 40) begin step(0, 0); n++; end
        check("wait_draw_bound", 32'(ph[i] == P_DRAW), 1);
    endtask

    initial begin
        model_reset();
        #12 check_all();
        rst_n = 1'b1;

        step(0, 0); step(0, 0);
        step(1, 0);
        step(0, 0); step(0, 0); step(0, 0);
        step(1, 0);
        wait_draw(0);
        step(1, 0);
        check("ovr_in_draw", 32'(ov[0]), 1);
        check("no_swap_on_ovr", 32'(bdp[0]), 0);
        step(0, 1); step(0, 0);
        step(1, 0);
        check("first_swap", 32'(bdp[0]), 1);
        wait_draw(0);
        step(1, 1);
        check("simul_swap", 32'(bdp[0]), 0);
        check("simul_no_ovr", 32'(ov[0]), 0);

        step(0, 0);
        mid_reset();
        step(1, 0);
        wait_draw(1);
        step(0, 1);
        step(1, 0); check("fw3_frame1", 32'(bdp[1]), 0);
        step(0, 0); step(0, 0);
        step(1, 0); check("fw3_frame2", 32'(bdp[1]), 0);
        step(0, 0);
        step(1, 0); check("fw3_frame3", 32'(bdp[1]), 1);

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 1499) == 0) mid_reset();
            step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
